// File: rtl/fifo_pkg.sv
// Shared async-FIFO definitions: pointer width and Gray-code helpers.
package fifo_pkg;

  localparam int FIFO_ADDRSIZE = 4;
  localparam int PTRW = FIFO_ADDRSIZE + 1;

  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

  // Narrower pointers are zero-extended, so the upper bits fold out cleanly.
  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b[31] = g[31];
    for (int i = 30; i >= 0; i--)
      b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser, parameterised width, sync active-high reset.
module sync_2ff #(
  parameter int W = 5
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_q1;
  logic [W-1:0] r_q2;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_q1 <= '0;
      r_q2 <= '0;
    end else begin
      r_q1 <= i_d;
      r_q2 <= r_q1;
    end
  end

  assign o_q = r_q2;

endmodule

// File: rtl/fifo_rd_ctrl.sv
// Async FIFO read side: read pointers, synchronised write pointer, flags.
module fifo_rd_ctrl
  import fifo_pkg::*;
#(
  parameter int ADDRSIZE     = FIFO_ADDRSIZE,
  parameter int ALMOST_EMPTY = 2
) (
  input  logic                i_rd_clk,
  input  logic                i_rd_rst,
  input  logic                i_rd_en,
  input  logic [ADDRSIZE:0]   i_wr_ptr,
  output logic                o_empty,
  output logic                o_almost_empty,
  output logic [ADDRSIZE-1:0] o_rd_addr,
  output logic [ADDRSIZE:0]   o_rd_ptr,
  output logic [ADDRSIZE:0]   o_rd_level,
  output logic                o_underflow
);

  localparam int PW = ADDRSIZE + 1;
  localparam logic [PW-1:0] AE_LVL = PW'(ALMOST_EMPTY);

  logic [PW-1:0] r_rd_bin;
  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_level;
  logic          r_empty;
  logic          r_almost;
  logic          r_uf;

  logic [PW-1:0] w_wq2;
  logic [PW-1:0] w_wbin;
  logic [PW-1:0] w_bin_nx;
  logic [PW-1:0] w_gray_nx;
  logic [PW-1:0] w_lvl_nx;
  logic          w_rd_ok;

  sync_2ff #(.W(PW)) u_wsync (
    .i_clk (i_rd_clk),
    .i_rst (i_rd_rst),
    .i_d   (i_wr_ptr),
    .o_q   (w_wq2)
  );

  assign w_rd_ok   = i_rd_en & ~r_empty;
  assign w_bin_nx  = r_rd_bin + PW'(w_rd_ok);
  assign w_gray_nx = PW'(bin2gray(32'(w_bin_nx)));
  assign w_wbin    = PW'(gray2bin(32'(w_wq2)));
  // Wrap-around subtraction; the extra MSB keeps full distinct from empty.
  assign w_lvl_nx  = w_wbin - w_bin_nx;

  always_ff @(posedge i_rd_clk) begin
    if (i_rd_rst) begin
      r_rd_bin <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_empty  <= 1'b1;
      r_almost <= 1'b1;
      r_uf     <= 1'b0;
    end else begin
      r_rd_bin <= w_bin_nx;
      r_rd_ptr <= w_gray_nx;
      r_level  <= w_lvl_nx;
      r_empty  <= (w_gray_nx == w_wq2);
      r_almost <= (w_lvl_nx <= AE_LVL);
      r_uf     <= r_uf | (i_rd_en & r_empty);
    end
  end

  assign o_empty        = r_empty;
  assign o_almost_empty = r_almost;
  assign o_rd_addr      = r_rd_bin[ADDRSIZE-1:0];
  assign o_rd_ptr       = r_rd_ptr;
  assign o_rd_level     = r_level;
  assign o_underflow    = r_uf;

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Randomised scoreboard bench for fifo_rd_ctrl against a count-based model.
module tb_fifo_rd_ctrl;

  localparam int AW = 4;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          rd_en;
  logic [AW:0]   wr_ptr;
  logic          empty;
  logic          almost;
  logic [AW-1:0] rd_addr;
  logic [AW:0]   rd_ptr;
  logic [AW:0]   rd_level;
  logic          uf;

  fifo_rd_ctrl #(.ADDRSIZE(AW), .ALMOST_EMPTY(2)) dut (
    .i_rd_clk       (clk),
    .i_rd_rst       (rst),
    .i_rd_en        (rd_en),
    .i_wr_ptr       (wr_ptr),
    .o_empty        (empty),
    .o_almost_empty (almost),
    .o_rd_addr      (rd_addr),
    .o_rd_ptr       (rd_ptr),
    .o_rd_level     (rd_level),
    .o_underflow    (uf)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit empty;
    bit almost;
    int ptr;
    int addr;
    int lvl;
    bit uf;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   failures = 0;

  // Model: write/read totals as plain counts; wr value seen 2 edges late.
  int wr_cnt, rd_cnt;
  int seen[$];
  bit m_empty, m_uf;

  function automatic int gray(input int b);
    return (b ^ (b >> 1)) & 31;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  always begin
    exp_t e;
    @(posedge clk);
    #1;
    if (sbq.size() != 0) begin
      e = sbq.pop_front();
      chk("empty", int'(empty), int'(e.empty));
      chk("almost_empty", int'(almost), int'(e.almost));
      chk("rd_ptr", int'(rd_ptr), e.ptr);
      chk("rd_addr", int'(rd_addr), e.addr);
      chk("rd_level", int'(rd_level), e.lvl);
      chk("underflow", int'(uf), int'(e.uf));
    end
  end

  task automatic step(input bit r, input bit en, input bit wr_inc);
    exp_t e;
    int lvl;
    @(negedge clk);
    if (r) begin
      wr_cnt = wr_cnt - rd_cnt;
      rd_cnt = 0;
    end else if (wr_inc && (wr_cnt + 1 - rd_cnt <= DEPTH)) begin
      wr_cnt++;
    end
    rst    = r;
    rd_en  = en;
    wr_ptr = 5'(gray(wr_cnt % 32));
    if (r) begin
      seen = '{0, 0};
      m_empty = 1'b1;
      m_uf = 1'b0;
      e = '{1'b1, 1'b1, 0, 0, 0, 1'b0};
    end else begin
      if (en && m_empty) m_uf = 1'b1;
      if (en && !m_empty) rd_cnt++;
      lvl = (seen[0] - (rd_cnt % 32)) & 31;
      m_empty = (lvl == 0);
      e = '{m_empty, lvl <= 2, gray(rd_cnt % 32), rd_cnt % 16, lvl, m_uf};
      void'(seen.pop_front());
      seen.push_back(wr_cnt % 32);
    end
    sbq.push_back(e);
  endtask

  initial begin
    int wp, rp;
    wr_cnt = 0;
    rd_cnt = 0;
    rst = 1'b1;
    rd_en = 1'b1;
    wr_ptr = '0;
    step(1, 1, 0);
    step(1, 1, 0);
    // Single write: empty must hold for two more edges
    step(0, 0, 1);
    repeat (4) step(0, 0, 0);
    step(0, 0, 1);
    step(0, 0, 1);
    repeat (3) step(0, 0, 0);
    // Drain past empty to hit underflow
    repeat (6) step(0, 1, 0);
    // Fill to depth, then read down
    repeat (22) step(0, 0, 1);
    repeat (14) step(0, 1, 0);
    // Mid-operation reset with entries pending
    repeat (5) step(0, 0, 1);
    repeat (3) step(0, 0, 0);
    step(1, 0, 0);
    repeat (5) step(0, 0, 0);
    // Random phases with varying write/read bias
    for (int ph = 0; ph < 24; ph++) begin
      wp = $urandom_range(10, 90);
      rp = $urandom_range(10, 90);
      for (int i = 0; i < 120; i++)
        step($urandom_range(0, 399) == 0,
             $urandom_range(0, 99) < rp,
             $urandom_range(0, 99) < wp);
    end
    repeat (3) @(posedge clk);
    #2;
    chk("scoreboard_drained", sbq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fifo_rd_ctrl.md
Name: fifo_rd_ctrl

Overview:
Read-side pointer and flag controller for the N-bit asynchronous FIFO, the counterpart of the write-side full/pointer logic.
- Runs entirely in the read clock domain.
- Synchronises the Gray-coded write pointer through two flops.
- Maintains the binary and Gray read pointers and drives the RAM read address.
- Produces registered empty, almost-empty, fill-level and sticky underflow indications.

Parameters:
- ADDRSIZE, 4: FIFO address width; depth = 2**ADDRSIZE; pointers are ADDRSIZE+1 bits.
- ALMOST_EMPTY, 2: o_almost_empty asserts when fill level <= this value; legal range 0..2**ADDRSIZE.

Ports:
- i_rd_clk  input  1  read-domain clock; only clock in the block.
- i_rd_rst  input  1  reset; synchronous, active-high.
- i_rd_en  input  1  read request; honoured only while o_empty=0.
- i_wr_ptr  input  ADDRSIZE+1  Gray write pointer from the write domain, unsynchronised.
- o_empty  output  1  registered empty flag.
- o_almost_empty  output  1  registered; fill level <= ALMOST_EMPTY.
- o_rd_addr  output  ADDRSIZE  RAM read address = rd_bin[ADDRSIZE-1:0].
- o_rd_ptr  output  ADDRSIZE+1  registered Gray read pointer, sent to the write domain.
- o_rd_level  output  ADDRSIZE+1  registered fill level as seen by the read side, 0..2**ADDRSIZE.
- o_underflow  output  1  sticky; set by a read attempt while empty.

Behaviour:
- Reset:
  - Condition: i_rd_rst=1 at a rising edge of i_rd_clk.
  - Cleared registers: rd_bin, o_rd_ptr, both synchroniser flops, o_rd_level, o_underflow all go to 0.
  - Flags: o_empty=1 and o_almost_empty=1.
  - Reset overrides every other input on that edge. Reset mid-operation discards all state.
  - The write side must be reset independently; the two domains are not coordinated here.
- Synchroniser: wq1 <= i_wr_ptr; wq2 <= wq1. Only wq2 is used downstream.
- Read advance:
  - rd_bin_next = rd_bin + (i_rd_en & ~o_empty), modulo 2**(ADDRSIZE+1).
  - rd_gray_next = (rd_bin_next >> 1) ^ rd_bin_next.
  - Each edge: rd_bin <= rd_bin_next; o_rd_ptr <= rd_gray_next.
- Empty:
  - o_empty <= (rd_gray_next == wq2), i.e. the compare uses the next pointer.
  - A read that consumes the last entry asserts o_empty on the same edge that advances the pointer.
- Level:
  - wbin = Gray-to-binary of wq2.
  - level_next = wbin - rd_bin_next, ADDRSIZE+1 bits with wrap-around subtraction.
  - o_rd_level <= level_next; o_almost_empty <= (level_next <= ALMOST_EMPTY).
- Underflow: o_underflow <= o_underflow | (i_rd_en & o_empty). Cleared only by reset.
- Read while empty: the pointer holds, o_rd_addr is unchanged, and no other state changes besides o_underflow.
- Latency:
  - A write-pointer change at i_wr_ptr reaches wq2 after 2 edges.
  - o_empty, o_rd_level and o_almost_empty reflect it on the 3rd edge.
  - The flags are pessimistic: they may show fewer entries than actually present, never more.
- Wrap-around:
  - Pointer MSB toggles each pass; o_rd_addr wraps from 2**ADDRSIZE-1 to 0.
  - Equal pointers mean empty. The write side never advances more than 2**ADDRSIZE ahead, so a level of 2**ADDRSIZE is the maximum.
- Simultaneous read and write-pointer update: legal. The read uses the current o_empty; the new write value is seen only via the synchroniser.

Decomposition:
- Shared package fifo_pkg holds:
  - the bin2gray and gray2bin functions, also to be adopted by the write-side logic;
  - the pointer-width localparam PTRW = ADDRSIZE+1.
- One sub-module: sync_2ff, a parameterised-width two-flop synchroniser with synchronous active-high reset. It is reusable by the write side for the read pointer.

Test Plan (ADDRSIZE=4, ALMOST_EMPTY=2):
1. Reset: i_rd_rst=1 for 2 edges, i_rd_en=1 -> o_empty=1, o_almost_empty=1, o_rd_ptr=0, o_rd_addr=0, o_rd_level=0, o_underflow=0.
2. Sync latency: i_wr_ptr 0 -> 5'b00001 before edge t -> o_empty=1 through edge t+1 and falls at edge t+2 (the 3rd edge, counting t); o_rd_level=1, o_almost_empty=1.
3. Drain plus underflow: i_wr_ptr=5'b00010 (bin 3) held, i_rd_en=1 for 4 cycles ->
   - o_rd_addr steps 0,1,2 and then holds at 3;
   - o_empty=1 on the edge of the 3rd read; o_rd_level goes 2,1,0;
   - the 4th read leaves the pointer unchanged and sets o_underflow=1, which stays 1.
4. Full level: i_wr_ptr=5'b11000 (bin 16), rd at 0 -> o_rd_level=16, o_almost_empty=0. Read 14 entries -> o_rd_level=2, o_almost_empty=1.
5. Wrap: i_wr_ptr=gray(20)=5'b11110, read 18 entries ->
   - after the 16th read: o_rd_ptr=5'b11000, o_rd_addr=0;
   - after the 18th read: o_rd_ptr=gray(18)=5'b11011, o_rd_addr=2, o_rd_level=2;
   - o_empty stays 0 throughout.
6. Mid-operation reset: at level 5 with o_underflow=1, pulse i_rd_rst=1 for 1 edge -> the reset values of scenario 1 on that edge. With i_wr_ptr still nonzero, o_empty falls 3 edges after reset release.
